// File: rtl/tile_spawner.sv
// rtl/tile_spawner.sv - scroll timer and LFSR lane picker feeding the Tiles row register
module tile_spawner #(
    parameter logic [23:0] TICK_INIT = 24'd6_000_000,
    parameter logic [23:0] TICK_MIN  = 24'd1_500_000,
    parameter logic [23:0] TICK_STEP = 24'd250_000,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        clear,
    input  logic        stall,
    input  logic        speedup,
    output logic [3:0]  new_tiles,
    output logic        shift,
    output logic [23:0] period,
    output logic [15:0] rows
);

    // An all-zero Galois LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE
    } state_t;

    state_t        r_state;
    logic [23:0]   r_counter;
    logic [23:0]   r_period;
    logic [15:0]   r_lfsr;
    logic [15:0]   r_rows;
    logic [1:0]    r_lane;

    logic          w_shift;
    logic [15:0]   w_lfsr_next;
    logic [1:0]    w_lane_next;
    logic [23:0]   w_period_dec;

    assign w_shift     = (r_state == ST_RUN) && !stall && (r_counter == 24'd0);
    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_MASK : 16'h0000);
    assign w_lane_next = (w_lfsr_next[1:0] == r_lane) ? (r_lane + 2'd1) : w_lfsr_next[1:0];

    // Compare before subtracting so the period never wraps below the floor.
    always_comb begin
        w_period_dec = TICK_MIN;
        if ((r_period >= TICK_STEP) && ((r_period - TICK_STEP) >= TICK_MIN))
            w_period_dec = r_period - TICK_STEP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_counter <= 24'd0;
            r_period  <= TICK_INIT;
            r_lfsr    <= SEED_EFF;
            r_lane    <= 2'd0;
            r_rows    <= 16'd0;
        end else if (clear) begin
            r_state   <= ST_IDLE;
            r_counter <= 24'd0;
            r_period  <= TICK_INIT;
            r_lfsr    <= SEED_EFF;
            r_lane    <= 2'd0;
            r_rows    <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= stall ? ST_PAUSE : ST_RUN;
                        r_counter <= r_period - 24'd1;
                    end
                end
                ST_RUN: begin
                    if (stall)
                        r_state <= ST_PAUSE;
                    else if (w_shift)
                        r_counter <= r_period - 24'd1;
                    else
                        r_counter <= r_counter - 24'd1;
                end
                ST_PAUSE: begin
                    if (!stall)
                        r_state <= ST_RUN;
                end
                default: r_state <= ST_IDLE;
            endcase

            if (speedup && (r_state != ST_IDLE))
                r_period <= w_period_dec;

            if (w_shift) begin
                r_lfsr <= w_lfsr_next;
                r_lane <= w_lane_next;
                if (r_rows != 16'hFFFF)
                    r_rows <= r_rows + 16'd1;
            end
        end
    end

    always_comb begin
        new_tiles = 4'b0000;
        if (r_state != ST_IDLE)
            new_tiles = 4'b0001 << r_lane;
    end

    assign shift  = w_shift;
    assign period = r_period;
    assign rows   = r_rows;

endmodule

// File: tb/tb_tile_spawner.sv
// tb/tb_tile_spawner.sv - directed bench for tile_spawner with a small period
module tb_tile_spawner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic        stall = 1'b0;
    logic        speedup = 1'b0;
    logic [3:0]  new_tiles, new_tiles0;
    logic        shift, shift0;
    logic [23:0] period, period0;
    logic [15:0] rows, rows0;

    int checks = 0;
    int failures = 0;

    logic        m_active;
    logic [15:0] m_lfsr;
    logic [1:0]  m_lane;
    logic [15:0] m_rows;
    logic [23:0] m_period;
    logic [3:0]  prev_tiles, cur_tiles, seen_mask;

    tile_spawner #(.TICK_INIT(24'd4), .TICK_MIN(24'd2), .TICK_STEP(24'd1), .SEED(16'hACE1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .stall(stall), .speedup(speedup),
        .new_tiles(new_tiles), .shift(shift), .period(period), .rows(rows)
    );

    tile_spawner #(.TICK_INIT(24'd4), .TICK_MIN(24'd2), .TICK_STEP(24'd1), .SEED(16'h0000)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .stall(stall), .speedup(speedup),
        .new_tiles(new_tiles0), .shift(shift0), .period(period0), .rows(rows0)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_lfsr   = 16'hACE1;
        m_lane   = 2'd0;
        m_rows   = 16'd0;
        m_period = 24'd4;
    endtask

    task automatic step(input logic exp_shift);
        logic [1:0] l;
        @(negedge clk);
        chk("shift", {31'd0, shift}, {31'd0, exp_shift});
        chk("new_tiles", {28'd0, new_tiles}, m_active ? {28'd0, 4'b0001 << m_lane} : 32'd0);
        chk("rows", {16'd0, rows}, {16'd0, m_rows});
        chk("period", {8'd0, period}, {8'd0, m_period});
        if (exp_shift) begin
            m_lfsr = lfsr_step(m_lfsr);
            l = m_lfsr[1:0];
            if (l == m_lane) l = l + 2'd1;
            m_lane = l;
            if (m_rows != 16'hFFFF) m_rows = m_rows + 16'd1;
        end
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_new_tiles", {28'd0, new_tiles}, 32'd0);
        chk("rst_shift", {31'd0, shift}, 32'd0);
        chk("rst_period", {8'd0, period}, 32'd4);
        chk("rst_rows", {16'd0, rows}, 32'd0);
        chk("rst_lfsr", {16'd0, dut.r_lfsr}, 32'h0000ACE1);
        chk("seed0_lfsr", {16'd0, dut0.r_lfsr}, 32'h00000001);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0);
        step(1'b0);

        // first shift three edges after the start edge, then every 4 cycles
        start = 1'b1;
        m_active = 1'b1;
        step(1'b0);
        start = 1'b0;
        step(1'b0);
        step(1'b0);
        step(1'b1);
        step(1'b0);
        chk("first_lane", {28'd0, new_tiles}, 32'h2);
        chk("seed0_first_lane", {28'd0, new_tiles0}, 32'h2);
        step(1'b0);
        step(1'b0);
        step(1'b1);
        step(1'b0);
        chk("seed0_second_lane", {28'd0, new_tiles0}, 32'h1);
        chk("seed0_rows", {16'd0, rows0}, 32'd2);
        step(1'b0);
        step(1'b0);
        step(1'b1);

        // stall for 10 cycles while the counter sits at 2
        step(1'b0);
        step(1'b0);
        stall = 1'b1;
        repeat (10) step(1'b0);
        stall = 1'b0;
        step(1'b0);
        step(1'b0);
        step(1'b1);

        // speedup on a shift cycle: that reload still uses period 4
        speedup = 1'b1;
        m_period = 24'd3;
        step(1'b0);
        speedup = 1'b0;
        step(1'b0);
        step(1'b0);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        step(1'b1);
        step(1'b0);
        speedup = 1'b1;
        m_period = 24'd2;
        step(1'b0);
        speedup = 1'b0;
        step(1'b1);
        step(1'b0);
        step(1'b1);
        speedup = 1'b1;
        step(1'b0);
        speedup = 1'b0;
        step(1'b1);

        // long run at period 2
        prev_tiles = 4'b0000;
        seen_mask  = 4'b0000;
        repeat (1000) begin
            step(1'b0);
            step(1'b1);
            cur_tiles = new_tiles;
            chk("no_repeat", {31'd0, cur_tiles != prev_tiles}, 32'd1);
            chk("lfsr_nonzero", {31'd0, dut.r_lfsr != 16'h0000}, 32'd1);
            seen_mask  = seen_mask | cur_tiles;
            prev_tiles = cur_tiles;
        end
        chk("all_lanes", {28'd0, seen_mask}, 32'hF);

        // asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_new_tiles", {28'd0, new_tiles}, 32'd0);
        chk("async_shift", {31'd0, shift}, 32'd0);
        chk("async_rows", {16'd0, rows}, 32'd0);
        chk("async_period", {8'd0, period}, 32'd4);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0);
        step(1'b0);
        step(1'b0);

        start = 1'b1;
        m_active = 1'b1;
        step(1'b0);
        start = 1'b0;
        step(1'b0);
        step(1'b0);
        step(1'b1);
        step(1'b0);

        // clear wins over a simultaneous start
        clear = 1'b1;
        start = 1'b1;
        model_reset();
        step(1'b0);
        clear = 1'b0;
        start = 1'b0;
        step(1'b0);
        speedup = 1'b1;
        step(1'b0);
        speedup = 1'b0;
        step(1'b0);
        chk("idle_speedup_period", {8'd0, period}, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
